// File: rtl/fetch_arbiter_if.sv
// Bundle of the consumer-side and memory-side read signals for fetch_arbiter.
//   consumer_read_valid/address : per-consumer read requests (packed, consumer i at [i*W +: W])
//   consumer_read_ready/data    : per-consumer completion pulse and held instruction
//   mem_read_valid/address      : request to program memory
//   mem_read_ready/data         : program memory response
// master : the arbiter's view; slave : the environment's view (fetch units + memory).
interface fetch_arbiter_if #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic                               mem_read_valid;
    logic [ADDR_BITS-1:0]               mem_read_address;
    logic                               mem_read_ready;
    logic [DATA_BITS-1:0]               mem_read_data;

    modport master (
        input  consumer_read_valid,
        input  consumer_read_address,
        output consumer_read_ready,
        output consumer_read_data,
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        output consumer_read_valid,
        output consumer_read_address,
        input  consumer_read_ready,
        input  consumer_read_data,
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter multiplexing several fetch units onto one program-memory read port.
// One transaction at a time: grant -> memory wait -> one-cycle ready pulse -> release.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_arbiter_if.master (consumer requests/responses and memory port)
module fetch_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4
) (
    input  logic              clk,
    input  logic              reset,
    fetch_arbiter_if.master   bus
);
    localparam int unsigned SEL_BITS = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESPOND  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [SEL_BITS-1:0]                rr_ptr, rr_ptr_d;
    logic [SEL_BITS-1:0]                grant, grant_d;
    logic                               mem_valid_q, mem_valid_d;
    logic [ADDR_BITS-1:0]               mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;

    logic [NUM_CONSUMERS-1:0]           rotated;
    logic                               found;
    logic [SEL_BITS-1:0]                winner;
    logic [ADDR_BITS-1:0]               winner_addr;
    logic                               grant_valid;

    // (base + off) mod NUM_CONSUMERS; both operands are below NUM_CONSUMERS
    function automatic logic [SEL_BITS-1:0] wrap_add(input logic [SEL_BITS-1:0] base,
                                                     input int unsigned off);
        logic [SEL_BITS:0] s;
        s = {1'b0, base} + (SEL_BITS+1)'(off);
        if (32'(s) >= NUM_CONSUMERS) begin
            s = s - (SEL_BITS+1)'(NUM_CONSUMERS);
        end
        return SEL_BITS'(s);
    endfunction

    // Round-robin scan: rotate requests so bit k is consumer (rr_ptr + k) mod N
    always_comb begin
        rotated = NUM_CONSUMERS'({bus.consumer_read_valid, bus.consumer_read_valid} >> rr_ptr);
        found   = 1'b0;
        winner  = '0;
        for (int k = 0; k < int'(NUM_CONSUMERS); k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr, k);
            end
        end
    end

    // Constant-base selects keep the per-consumer muxes simple
    always_comb begin
        winner_addr = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
            if (winner == SEL_BITS'(i)) begin
                winner_addr = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
            end
            if (grant == SEL_BITS'(i)) begin
                grant_valid = bus.consumer_read_valid[i];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr;
        grant_d     = grant;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = ready_q;
        data_d      = data_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = winner;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = winner_addr;
                    state_d     = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_read_ready) begin
                    mem_valid_d = 1'b0;
                    for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
                        if (grant == SEL_BITS'(i)) begin
                            data_d[i*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
                            ready_d[i]                       = 1'b1;
                        end
                    end
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                ready_d = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                // Wait for the served consumer to drop its request so it is not re-served
                if (!grant_valid) begin
                    rr_ptr_d = wrap_add(grant, 1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr      <= rr_ptr_d;
            grant       <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
        end
    end

    assign bus.mem_read_valid      = mem_valid_q;
    assign bus.mem_read_address    = mem_addr_q;
    assign bus.consumer_read_ready = ready_q;
    assign bus.consumer_read_data  = data_q;
endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed self-checking bench for fetch_arbiter (4 consumers, 8-bit address, 16-bit data).
module tb_fetch_arbiter;
    localparam int unsigned AB = 8;
    localparam int unsigned DB = 16;
    localparam int unsigned NC = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) bus ();

    fetch_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant, answers with zero wait states, then the consumer
    // drops valid one cycle after seeing ready, as fetch does.
    task automatic serve_one(input int cons, input logic [AB-1:0] addr, input logic [DB-1:0] data);
        logic [NC-1:0] onehot;
        onehot = NC'(1) << cons;
        for (int k = 0; k < 10 && bus.mem_read_valid !== 1'b1; k++) tick;
        check("grant_valid", 64'(bus.mem_read_valid), 64'(1));
        check("grant_addr", 64'(bus.mem_read_address), 64'(addr));
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = data;
        tick;
        bus.mem_read_ready = 1'b0;
        check("ready_pulse", 64'(bus.consumer_read_ready), 64'(onehot));
        check("slot_data", 64'(bus.consumer_read_data[cons*DB +: DB]), 64'(data));
        check("mem_valid_drop", 64'(bus.mem_read_valid), 64'(0));
        tick;
        check("ready_clear", 64'(bus.consumer_read_ready), 64'(0));
        bus.consumer_read_valid[cons] = 1'b0;
        tick;
    endtask

    initial begin
        reset                     = 1'b0;
        bus.consumer_read_valid   = '0;
        bus.consumer_read_address = '0;
        bus.mem_read_ready        = 1'b0;
        bus.mem_read_data         = '0;
        for (int i = 0; i < int'(NC); i++) begin
            bus.consumer_read_address[i*AB +: AB] = AB'(32'h10 + i);
        end
        tick;
        tick;

        // Reset values
        check("rst_mem_valid", 64'(bus.mem_read_valid), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_read_address), 64'(0));
        check("rst_ready", 64'(bus.consumer_read_ready), 64'(0));
        check("rst_data", 64'(bus.consumer_read_data), 64'(0));
        check("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
        reset = 1'b1;
        tick;
        check("idle_no_req", 64'(bus.mem_read_valid), 64'(0));

        // Consumers 1 and 3 together: 1 first, then 3, pointer wraps to 0
        bus.consumer_read_valid = 4'b1010;
        serve_one(1, 8'h11, 16'hA001);
        serve_one(3, 8'h13, 16'hA003);
        check("rr_after_3", 64'(dut.rr_ptr), 64'(0));
        check("slot1_kept", 64'(bus.consumer_read_data[1*DB +: DB]), 64'(16'hA001));

        // All four requesting continuously: order 0,1,2,3,0,1
        bus.consumer_read_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            serve_one(n % 4, AB'(32'h10 + (n % 4)), DB'(32'hB000 + n));
            if (n < 5) bus.consumer_read_valid[n % 4] = 1'b1;
        end
        bus.consumer_read_valid = '0;
        check("rr_after_cont", 64'(dut.rr_ptr), 64'(2));

        // Single request, consumer 2 @0x15, valid held one extra cycle in RELEASE
        bus.consumer_read_address[2*AB +: AB] = 8'h15;
        bus.consumer_read_valid = 4'b0100;
        tick;
        check("single_valid", 64'(bus.mem_read_valid), 64'(1));
        check("single_addr", 64'(bus.mem_read_address), 64'(8'h15));
        check("single_no_early_rdy", 64'(bus.consumer_read_ready), 64'(0));
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'h7A3C;
        tick;
        bus.mem_read_ready = 1'b0;
        check("single_pulse", 64'(bus.consumer_read_ready), 64'(4'b0100));
        check("single_data", 64'(bus.consumer_read_data[2*DB +: DB]), 64'(16'h7A3C));
        check("single_mem_drop", 64'(bus.mem_read_valid), 64'(0));
        tick;
        check("single_pulse_end", 64'(bus.consumer_read_ready), 64'(0));
        tick;
        check("single_hold_noreq", 64'(bus.mem_read_valid), 64'(0));
        check("single_hold_nordy", 64'(bus.consumer_read_ready), 64'(0));
        bus.consumer_read_valid = '0;
        tick;
        tick;
        check("single_no_rereq", 64'(bus.mem_read_valid), 64'(0));
        check("single_rr", 64'(dut.rr_ptr), 64'(3));

        // Memory wait states: consumer 0, ready low for 3 cycles
        bus.consumer_read_address[0*AB +: AB] = 8'h2A;
        bus.consumer_read_valid = 4'b0001;
        tick;
        check("ws_valid", 64'(bus.mem_read_valid), 64'(1));
        check("ws_addr", 64'(bus.mem_read_address), 64'(8'h2A));
        for (int w = 0; w < 3; w++) begin
            tick;
            check("ws_valid_hold", 64'(bus.mem_read_valid), 64'(1));
            check("ws_addr_hold", 64'(bus.mem_read_address), 64'(8'h2A));
            check("ws_no_rdy", 64'(bus.consumer_read_ready), 64'(0));
        end
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'hC0DE;
        tick;
        bus.mem_read_ready = 1'b0;
        check("ws_pulse", 64'(bus.consumer_read_ready), 64'(4'b0001));
        check("ws_data", 64'(bus.consumer_read_data[0*DB +: DB]), 64'(16'hC0DE));
        tick;
        check("ws_pulse_end", 64'(bus.consumer_read_ready), 64'(0));
        bus.consumer_read_valid = '0;
        tick;

        // Consumer 0 changes address and drops valid after grant
        bus.consumer_read_address[0*AB +: AB] = 8'h40;
        bus.consumer_read_valid = 4'b0001;
        tick;
        check("chg_addr", 64'(bus.mem_read_address), 64'(8'h40));
        bus.consumer_read_address[0*AB +: AB] = 8'h7F;
        bus.consumer_read_valid = '0;
        tick;
        check("chg_valid_hold", 64'(bus.mem_read_valid), 64'(1));
        check("chg_addr_hold", 64'(bus.mem_read_address), 64'(8'h40));
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'h1234;
        tick;
        bus.mem_read_ready = 1'b0;
        check("chg_pulse", 64'(bus.consumer_read_ready), 64'(4'b0001));
        check("chg_data", 64'(bus.consumer_read_data[0*DB +: DB]), 64'(16'h1234));
        tick;
        check("chg_pulse_end", 64'(bus.consumer_read_ready), 64'(0));
        check("chg_in_release", 64'(dut.state_q), 64'(3));
        tick;
        check("chg_back_idle", 64'(dut.state_q), 64'(0));
        check("chg_rr", 64'(dut.rr_ptr), 64'(1));
        check("slot2_kept", 64'(bus.consumer_read_data[2*DB +: DB]), 64'(16'h7A3C));

        // Reset during MEM_WAIT for consumer 1, then the pending request is served
        bus.consumer_read_address[1*AB +: AB] = 8'h33;
        bus.consumer_read_valid = 4'b0010;
        tick;
        check("rm_valid", 64'(bus.mem_read_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("rm_mem_valid", 64'(bus.mem_read_valid), 64'(0));
        check("rm_mem_addr", 64'(bus.mem_read_address), 64'(0));
        check("rm_data", 64'(bus.consumer_read_data), 64'(0));
        check("rm_rr", 64'(dut.rr_ptr), 64'(0));
        tick;
        check("rm_hold_idle", 64'(dut.state_q), 64'(0));
        reset = 1'b1;
        serve_one(1, 8'h33, 16'h5A5A);
        check("rm_rr_after", 64'(dut.rr_ptr), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_arbiter.md
# fetch_arbiter

Arbitrates instruction reads from several `fetch` units onto the single program-memory read port. Each consumer side uses the same valid/ready handshake that `fetch` drives. The block sits between the per-core fetch stages and program memory. It serves one request at a time, chooses between requesters in round-robin order, and holds each returned instruction stable for its consumer.

## Interface
- `ADDR_BITS`, default 8: program memory address width.
- `DATA_BITS`, default 16: instruction width.
- `NUM_CONSUMERS`, default 4: number of fetch units served. Must be at least 2. `SEL_BITS = $clog2(NUM_CONSUMERS)`.

- `clk` input 1: the single clock. All state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. While low, all state is held at its reset value.
- `consumer_read_valid` input NUM_CONSUMERS: per-consumer read request.
- `consumer_read_address` input NUM_CONSUMERS*ADDR_BITS: per-consumer address. Consumer i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- `consumer_read_ready` output NUM_CONSUMERS: per-consumer one-cycle completion pulse.
- `consumer_read_data` output NUM_CONSUMERS*DATA_BITS: per-consumer returned instruction, packed the same way as the addresses.
- `mem_read_valid` output 1: request to program memory.
- `mem_read_address` output ADDR_BITS: address sent to program memory.
- `mem_read_ready` input 1: memory response. Data is valid in any cycle where this is high.
- `mem_read_data` input DATA_BITS: memory read data.

## Operation
- A single FSM with four states: IDLE, MEM_WAIT, RESPOND, RELEASE.
- Registered state:
  - round-robin pointer `rr_ptr` (SEL_BITS wide)
  - grant index `grant` (SEL_BITS wide)
  - all outputs
- IDLE:
  - Scan `consumer_read_valid` starting at index `rr_ptr`, wrapping from NUM_CONSUMERS-1 to 0. The first set bit wins.
  - If there is a winner: set `grant` to the winner, set `mem_read_valid` to 1, set `mem_read_address` to that consumer's address, and go to MEM_WAIT.
  - If there is no winner: stay in IDLE. All outputs hold.
- MEM_WAIT:
  - While `mem_read_ready` is 0: hold `mem_read_valid` and `mem_read_address` unchanged.
  - When `mem_read_ready` is 1:
    - `mem_read_valid` goes to 0.
    - Write `mem_read_data` into the `grant` slot of `consumer_read_data`.
    - `consumer_read_ready[grant]` goes to 1.
    - Go to RESPOND.
- RESPOND:
  - `consumer_read_ready[grant]` goes to 0, so the pulse is exactly one cycle wide.
  - Go to RELEASE.
- RELEASE:
  - The FSM must not re-serve a consumer whose valid is still high from the request it just completed. (`fetch` drops valid one cycle after it sees ready.)
  - Stay in RELEASE while `consumer_read_valid[grant]` is 1.
  - When it is 0: set `rr_ptr` to `grant`+1, wrapping from NUM_CONSUMERS-1 to 0, and go to IDLE.
- Each `consumer_read_data` slot holds its value until that consumer is next served. Other consumers' slots are never disturbed.
- The address is captured at grant time. Changes on `consumer_read_address` after the grant have no effect.
- If the granted consumer drops valid mid-transaction, the memory read still completes and the ready pulse is still issued. RELEASE then exits on its first cycle.
- Requests that arrive while a transaction is in progress wait. They are never lost, because each consumer holds valid until it is served.
- At most one consumer's `consumer_read_ready` bit is ever high. `mem_read_valid` is never high outside MEM_WAIT.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `grant` = 0
  - `mem_read_valid` = 0, `mem_read_address` = 0
  - all `consumer_read_ready` bits = 0, all `consumer_read_data` bits = 0
- Reset asserted mid-transaction aborts immediately; the memory request is dropped. After release the block restarts in IDLE with `rr_ptr` = 0.
- Latency, with consumer valid sampled high at edge 0 and memory answering in the first cycle it sees valid:
  - `mem_read_valid` is high after edge 0.
  - `mem_read_ready` is sampled at edge 1.
  - `consumer_read_ready` is high for the cycle between edge 1 and edge 2.
  - This is 2 cycles from request to ready, plus one cycle per memory wait state.
- Minimum spacing between the starts of two grants is 4 cycles: grant, response, pulse, release.

## Test plan
- Single request: consumer 2 requests address 0x15, memory returns 0x7A3C with zero wait. Required:
  - `mem_read_address` = 0x15.
  - `consumer_read_ready` = 4'b0100 for exactly one cycle.
  - Slot 2 of `consumer_read_data` = 0x7A3C and stays so afterwards.
  - No second memory request while consumer 2's valid falls.
- Simultaneous requests from consumers 1 and 3 right after reset. Required: consumer 1 is served first, then consumer 3, with `rr_ptr` = 0 after consumer 3 is served.
- All four consumers request continuously, re-asserting after each completion. Required: grant order 0,1,2,3,0,1; no consumer is served twice before every other consumer has been served once.
- Memory holds `mem_read_ready` low for 3 cycles. Required: `mem_read_valid` and `mem_read_address` stay stable throughout; the consumer's ready pulse occurs on the cycle after ready is sampled.
- Reset pulled low during MEM_WAIT for consumer 1. Required: all outputs return to 0 immediately. After release, a pending request from consumer 1 is served normally.
- Consumer 0 changes its address and drops valid after being granted. Required: memory sees the original address, consumer 0 still gets one ready pulse, and the FSM returns to IDLE after one RELEASE cycle.
